line_read_responder: RTL and testbench
======================================

# line_read_responder

Memory-side responder for the cache read protocol: it answers the `mem_read`/`mem_resp` requests issued by the L2-side fetch path, including the prefetcher. Each miss becomes a fixed-length burst of 64-bit beats to physical memory, which is assembled into one 256-bit line. It keeps a single-entry last-line buffer, so repeat reads of the same line (common under prefetch) complete without a burst.

## Interface
- `LINE_WIDTH`, 256: line width in bits; also fixes the offset bits ignored in the address (log2(LINE_WIDTH/8) = 5).
- `BEAT_WIDTH`, 64: burst beat width. BEATS = LINE_WIDTH/BEAT_WIDTH = 4.
- `clk`  in  1  single clock; all state updates on the posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  upstream read request; held high until `mem_resp`.
- `mem_address`  in  32  upstream byte address; stable while `mem_read` is high.
- `mem_rdata`  out  LINE_WIDTH  returned line; valid in the `mem_resp` cycle.
- `mem_resp`  out  1  one-cycle completion pulse.
- `inval`  in  1  invalidate the line buffer (an external write hit this memory).
- `pmem_read`  out  1  burst request to physical memory.
- `pmem_address`  out  32  line-aligned burst address (`addr[31:5]`, `5'b0`).
- `pmem_rdata`  in  BEAT_WIDTH  burst beat data.
- `pmem_resp`  in  1  beat valid; beats may be non-consecutive.

## Operation
- Internal state:
  - FSM: IDLE, BURST, RESP.
  - `line_buf[LINE_WIDTH]`, `tag[26:0]`, `valid`.
  - `beat_cnt[1:0]`, `req_addr[31:0]`, `kill` flag.
- IDLE:
  - `mem_read` and `valid` and `mem_address[31:5] == tag` → hit → RESP. No pmem traffic.
  - `mem_read` on a miss → latch aligned `req_addr`, clear `beat_cnt`, → BURST.
  - No `mem_read` → stay in IDLE.
- BURST:
  - `pmem_read` = 1; `pmem_address` = `req_addr`, constant for the whole burst.
  - On each `pmem_resp`: write `pmem_rdata` into slice `beat_cnt` (beat 0 → bits 63:0, beat 3 → bits 255:192), then `beat_cnt`++.
  - On the 4th beat: `tag` ← `req_addr[31:5]`, `valid` ← !(`kill` | `inval`), clear `kill`, → RESP.
- RESP:
  - `mem_resp` = 1 for exactly one cycle; `mem_rdata` = `line_buf`.
  - `pmem_read` = 0; then → IDLE unconditionally.
- `mem_rdata` is driven from `line_buf` at all times and is only meaningful in the `mem_resp` cycle.
- Low 5 address bits are ignored everywhere. Two requests differing only in bits 4:0 hit the same line.
- `inval`:
  - In IDLE/RESP it clears `valid` on the next edge. An IDLE hit check in the same cycle as `inval` is treated as a miss.
  - In BURST it sets `kill`. The burst still completes and the line is returned, but it is not marked valid.
- `pmem_resp` in IDLE/RESP is ignored. Extra beats beyond 4 are not expected and are not sampled.
- `mem_read` dropping mid-burst is a protocol violation. The burst completes and `mem_resp` still pulses.

## Timing
- Reset (async, immediate):
  - State IDLE; `valid`=0, `kill`=0, `beat_cnt`=0, `tag`=0, `line_buf`=0.
  - `mem_resp`=0, `pmem_read`=0, `pmem_address`=0, `mem_rdata`=0.
- Reset mid-burst abandons the burst. `pmem_read` drops asynchronously and no `mem_resp` is issued.
- Hit latency: `mem_read` sampled in cycle N → `mem_resp` in cycle N+1.
- Miss latency:
  - `pmem_read` rises in cycle N+1.
  - `mem_resp` comes 1 cycle after the edge that samples the 4th `pmem_resp`.
  - With back-to-back beats in N+1..N+4, `mem_resp` is in N+5.
- Back-to-back requests: after `mem_resp` the block is in IDLE the next cycle. A still-high `mem_read` there is taken as a new request, so one request completes at most every 2 cycles.
- `mem_rdata` holds its value until the next miss begins filling.

## Test plan
- Cold miss, then repeat read:
  - Reset; read 0x0000_1024; pmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  - Required: `pmem_address`=0x0000_1020; `mem_resp` at cycle 5; `mem_rdata`=0x44..44_33..33_22..22_11..11.
  - Required: a repeat read of 0x0000_103C gives `mem_resp` next cycle with no `pmem_read`.
- Gapped beats: beats arrive with 2 idle cycles between each → `beat_cnt` holds across gaps, one `mem_resp` after the 4th beat, line assembled correctly.
- Line change: read 0x1020 then 0x1040 → the second read is a miss with a new burst at `pmem_address` 0x1040; the buffer then holds 0x1040.
- Invalidate:
  - `inval` in IDLE after filling 0x1020, then read 0x1020 → full burst is reissued.
  - `inval` during a burst → line is returned, and the next read of the same line is a miss.
- Streaming (held `mem_read` with stride 0x20 across 3 lines) → 3 bursts, 3 single-cycle `mem_resp` pulses, each separated by ≥1 IDLE cycle.
- Async reset after beat 2 of a burst → `pmem_read` low with no clock edge, no `mem_resp`, `valid`=0; the next read of the same line reissues the full burst.

Source files
------------

// File: rtl/line_read_responder.sv
// Memory-side line read responder: bursts beats from physical memory into
// one line and keeps a single-entry last-line buffer for repeat reads.
module line_read_responder #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic [31:0]           mem_address,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  input  logic                  inval,
  output logic                  pmem_read,
  output logic [31:0]           pmem_address,
  input  logic [BEAT_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int TAGW  = 32 - OFFS;
  localparam int CW    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RESP
  } state_e;

  state_e                state_q;
  logic [LINE_WIDTH-1:0] line_buf_q;
  logic [TAGW-1:0]       tag_q;
  logic                  valid_q;
  logic                  kill_q;
  logic [CW-1:0]         beat_cnt_q;
  logic [31:0]           req_addr_q;
  logic                  mem_resp_q;
  logic                  pmem_read_q;

  logic hit;
  logic last_beat;
  logic unused_offs;

  assign hit       = valid_q && !inval
                   && (mem_address[31:OFFS] == tag_q);
  assign last_beat = (beat_cnt_q == CW'(BEATS - 1));
  assign unused_offs = ^mem_address[OFFS-1:0];

  assign mem_rdata    = line_buf_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = req_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_buf_q  <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      kill_q      <= 1'b0;
      beat_cnt_q  <= '0;
      req_addr_q  <= '0;
      mem_resp_q  <= 1'b0;
      pmem_read_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inval) valid_q <= 1'b0;
          if (mem_read) begin
            if (hit) begin
              mem_resp_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              req_addr_q  <= {mem_address[31:OFFS], {OFFS{1'b0}}};
              beat_cnt_q  <= '0;
              pmem_read_q <= 1'b1;
              state_q     <= BURST;
            end
          end
        end
        BURST: begin
          if (inval) kill_q <= 1'b1;
          if (pmem_resp) begin
            line_buf_q[BEAT_WIDTH*beat_cnt_q +: BEAT_WIDTH] <= pmem_rdata;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            // an invalidate seen anywhere in the burst leaves the line unusable
            if (last_beat) begin
              tag_q       <= req_addr_q[31:OFFS];
              valid_q     <= !(kill_q || inval);
              kill_q      <= 1'b0;
              pmem_read_q <= 1'b0;
              mem_resp_q  <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (inval) valid_q <= 1'b0;
          mem_resp_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_read_responder.sv
// Scoreboard bench for line_read_responder: driver pushes expected lines,
// a pmem model serves beats, and a monitor checks each mem_resp.
module tb_line_read_responder;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         inval;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  line_read_responder dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .inval        (inval),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference: the last line held, its line number, and whether it is usable
  logic         m_valid = 1'b0;
  logic [26:0]  m_tag   = '0;
  logic [255:0] m_line  = '0;

  logic [255:0] exp_line_q[$];
  int           exp_nb_q[$];
  logic [63:0]  beat_q[$];
  logic [31:0]  paddr_q[$];
  int           served = 0;
  int           last_served = 0;
  int           gap = 0;
  int           gap_cnt = 0;
  int           bidx = 0;
  bit           prev_resp = 1'b0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // physical memory: serves queued beats with a programmable gap
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (pmem_read && beat_q.size() > 0) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          chk("pmem_address", 256'(pmem_address), 256'(paddr_q[0]));
          pmem_rdata = beat_q.pop_front();
          pmem_resp  = 1'b1;
          served++;
          bidx++;
          gap_cnt = gap;
          if (bidx == 4) begin
            bidx = 0;
            gap_cnt = 0;
            paddr_q.delete(0);
          end
        end
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_resp = 1'b0;
    end else begin
      if (mem_resp) begin
        chk("resp_single_cycle", 256'(prev_resp), 256'(0));
        if (exp_line_q.size() == 0) begin
          chk("unexpected_resp", 256'(1), 256'(0));
        end else begin
          chk("mem_rdata", mem_rdata, exp_line_q.pop_front());
          chk("burst_beats", 256'(served - last_served),
              256'(exp_nb_q.pop_front()));
        end
        last_served = served;
      end
      prev_resp = mem_resp;
    end
  end

  task automatic do_read(input logic [31:0] a, input int g, input bit keep,
                         input bit inv_now, input bit inv_burst,
                         input bit pat);
    logic [255:0] line;
    logic [63:0]  b;
    bit           hit;
    int           lat;
    hit = m_valid && !inv_now && (a[31:5] == m_tag);
    if (hit) begin
      exp_line_q.push_back(m_line);
      exp_nb_q.push_back(0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        b = pat ? {8{8'(8'h11 * (i + 1))}} : {$urandom, $urandom};
        line[i*64 +: 64] = b;
        beat_q.push_back(b);
      end
      paddr_q.push_back({a[31:5], 5'b0});
      exp_line_q.push_back(line);
      exp_nb_q.push_back(4);
      m_line  = line;
      m_tag   = a[31:5];
      m_valid = !inv_burst;
    end
    gap = g;
    mem_read = 1'b1;
    mem_address = a;
    inval = inv_now;
    lat = 0;
    @(negedge clk);
    while (!mem_resp && lat < 200) begin
      @(negedge clk);
      lat++;
      inval = inv_burst && !hit && lat == 2;
    end
    inval = 1'b0;
    if (lat >= 200) chk("resp_timeout", 256'(1), 256'(0));
    else if (hit) chk("hit_latency", 256'(lat), 256'(1));
    else chk("miss_latency", 256'(lat), 256'(5 + 3 * g));
    @(posedge clk);
    #1;
    if (!keep) mem_read = 1'b0;
  endtask

  task automatic pulse_inval();
    @(posedge clk);
    #1 inval = 1'b1;
    @(posedge clk);
    #1 inval = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic reset_mid_burst(input logic [31:0] a);
    int base;
    int t;
    base = served;
    for (int i = 0; i < 4; i++) beat_q.push_back({$urandom, $urandom});
    paddr_q.push_back({a[31:5], 5'b0});
    gap = 0;
    mem_read = 1'b1;
    mem_address = a;
    t = 0;
    while (served - base < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reset_wait_beats", 256'(served - base >= 2), 256'(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_pmem_read", 256'(pmem_read), 256'(0));
    chk("async_mem_resp", 256'(mem_resp), 256'(0));
    beat_q.delete();
    paddr_q.delete();
    bidx = 0;
    gap_cnt = 0;
    mem_read = 1'b0;
    last_served = served;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_rdata", mem_rdata, 256'(0));
    m_valid = 1'b0;
    m_line  = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    bit          k;
    bit          prev_keep;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_address = '0;
    inval = 1'b0;
    #23;
    chk("rst_mem_resp", 256'(mem_resp), 256'(0));
    chk("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("rst_pmem_address", 256'(pmem_address), 256'(0));
    chk("rst_mem_rdata", mem_rdata, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_read(32'h0000_1024, 0, 0, 0, 0, 1);
    chk("cold_line", mem_rdata,
        {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    do_read(32'h0000_103C, 0, 0, 0, 0, 0);
    do_read(32'h0000_2000, 2, 0, 0, 0, 0);
    do_read(32'h0000_1020, 0, 0, 0, 0, 0);
    do_read(32'h0000_1040, 1, 0, 0, 0, 0);
    do_read(32'h0000_1050, 0, 0, 0, 0, 0);
    pulse_inval();
    do_read(32'h0000_1040, 0, 0, 0, 0, 0);
    do_read(32'h0000_3000, 1, 0, 0, 1, 0);
    do_read(32'h0000_3008, 0, 0, 0, 0, 0);
    do_read(32'h0000_3010, 0, 0, 0, 0, 0);
    do_read(32'h0000_3004, 0, 0, 1, 0, 0);
    do_read(32'h0000_4000, 0, 1, 0, 0, 0);
    do_read(32'h0000_4020, 1, 1, 0, 0, 0);
    do_read(32'h0000_4040, 0, 0, 0, 0, 0);
    reset_mid_burst(32'h0000_5000);
    do_read(32'h0000_5000, 0, 0, 0, 0, 0);
    do_read(32'h0000_501F, 0, 0, 0, 0, 0);

    prev_keep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 32'h20
        + 32'($urandom_range(0, 31));
      k = ($urandom_range(0, 3) == 0) && (i != 39);
      if (!prev_keep && $urandom_range(0, 5) == 0) pulse_inval();
      do_read(a, int'($urandom_range(0, 3)), k,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 0);
      prev_keep = k;
    end
    mem_read = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 256'(exp_line_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
